// File: rtl/stb_drain_ctrl_pkg.sv
// Shared types for the data-cache port arbiter.
//   arb_state_e  : arbiter FSM states
//   cache_op_t   : operation latched at grant (is_store, addr, data, size)
//   data_size_e  : store access size
//   line_addr()  : clears the line-offset bits of an address
package stb_drain_ctrl_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int XLEN             = 32;
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } data_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                     is_store;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [XLEN-1:0]          data;
        data_size_e               size;
    } cache_op_t;

    function automatic logic [ADDRESS_WIDTH-1:0] line_addr(input logic [ADDRESS_WIDTH-1:0] a);
        return {a[ADDRESS_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/stb_drain_ctrl.sv
// Arbiter and sequencer for the single data-cache port in the Cache stage.
// Pipeline loads and store-buffer drains compete for the port; each granted
// operation does a lookup, and on a miss a memory refill followed by a retry.
// A starvation counter forces a drain after STARVE_LIMIT consecutive load
// grants while a drain is pending.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   ld_req_in/ld_addr_in        load request (level) and address
//   ld_done_out                 load hit data valid this cycle (pulse)
//   stb_flush_in, stb_*_in      store-buffer head entry waiting to drain
//   stb_ack_out                 head entry written, pop it (pulse)
//   cache_*_out, cache_hit_in   lookup / write interface to the cache
//   mem_req_out/mem_addr_out    line refill request (level) and line address
//   mem_ready_in                refill installed
//   stall_out                   Cache-stage pipeline stall
//
// state  | meaning
// IDLE   | arbitrate between load and drain, latch winner into op_q
// LOOKUP | cache lookup (and write on store hit) for op_q
// REFILL | waiting for the memory refill of op_q's line
module stb_drain_ctrl
    import stb_drain_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = ADDRESS_WIDTH,
    parameter int DATA_W       = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req_in,
    input  logic [ADDR_W-1:0] ld_addr_in,
    output logic              ld_done_out,
    input  logic              stb_flush_in,
    input  logic [ADDR_W-1:0] stb_addr_in,
    input  logic [DATA_W-1:0] stb_data_in,
    input  data_size_e        stb_size_in,
    output logic              stb_ack_out,
    output logic              cache_req_out,
    output logic              cache_we_out,
    output logic [ADDR_W-1:0] cache_addr_out,
    output logic [DATA_W-1:0] cache_wdata_out,
    output data_size_e        cache_size_out,
    input  logic              cache_hit_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ready_in,
    output logic              stall_out
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state_q, state_d;
    cache_op_t        op_q, op_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic starved;
    logic grant_st;
    logic grant_ld;

    always_comb begin
        starved  = (starve_q == CNT_W'(STARVE_LIMIT));
        grant_st = (state_q == IDLE) & stb_flush_in & (~ld_req_in | starved);
        grant_ld = (state_q == IDLE) & ld_req_in & ~grant_st;
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        starve_d        = starve_q;
        ld_done_out     = 1'b0;
        stb_ack_out     = 1'b0;
        cache_req_out   = 1'b0;
        cache_we_out    = 1'b0;
        cache_addr_out  = '0;
        cache_wdata_out = '0;
        cache_size_out  = SIZE_BYTE;
        mem_req_out     = 1'b0;
        mem_addr_out    = '0;
        stall_out       = 1'b0;

        case (state_q)
            IDLE: begin
                // A load presented here but not granted must hold the pipe.
                stall_out = ld_req_in & ~grant_ld;
                if (grant_st) begin
                    op_d.is_store = 1'b1;
                    op_d.addr     = stb_addr_in;
                    op_d.data     = stb_data_in;
                    op_d.size     = stb_size_in;
                    starve_d      = '0;
                    state_d       = LOOKUP;
                end else if (grant_ld) begin
                    op_d      = '0;
                    op_d.addr = ld_addr_in;
                    if (stb_flush_in && !starved) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = LOOKUP;
                end
                if (!stb_flush_in) begin
                    starve_d = '0;
                end
            end
            LOOKUP: begin
                cache_req_out   = 1'b1;
                cache_addr_out  = op_q.addr;
                cache_wdata_out = op_q.data;
                cache_size_out  = op_q.size;
                stall_out       = 1'b1;
                if (cache_hit_in) begin
                    state_d = IDLE;
                    if (op_q.is_store) begin
                        cache_we_out = 1'b1;
                        stb_ack_out  = 1'b1;
                    end else begin
                        ld_done_out = 1'b1;
                        stall_out   = 1'b0;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req_out  = 1'b1;
                mem_addr_out = line_addr(op_q.addr);
                stall_out    = 1'b1;
                if (mem_ready_in) begin
                    state_d = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_stb_drain_ctrl.sv
module tb_stb_drain_ctrl;
    import stb_drain_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req_in;
    logic [31:0] ld_addr_in;
    logic        ld_done_out;
    logic        stb_flush_in;
    logic [31:0] stb_addr_in;
    logic [31:0] stb_data_in;
    data_size_e  stb_size_in;
    logic        stb_ack_out;
    logic        cache_req_out;
    logic        cache_we_out;
    logic [31:0] cache_addr_out;
    logic [31:0] cache_wdata_out;
    data_size_e  cache_size_out;
    logic        cache_hit_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ready_in;
    logic        stall_out;

    always #5 clk = ~clk;

    stb_drain_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ld_req_in      (ld_req_in),
        .ld_addr_in     (ld_addr_in),
        .ld_done_out    (ld_done_out),
        .stb_flush_in   (stb_flush_in),
        .stb_addr_in    (stb_addr_in),
        .stb_data_in    (stb_data_in),
        .stb_size_in    (stb_size_in),
        .stb_ack_out    (stb_ack_out),
        .cache_req_out  (cache_req_out),
        .cache_we_out   (cache_we_out),
        .cache_addr_out (cache_addr_out),
        .cache_wdata_out(cache_wdata_out),
        .cache_size_out (cache_size_out),
        .cache_hit_in   (cache_hit_in),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_ready_in   (mem_ready_in),
        .stall_out      (stall_out)
    );

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        data_size_e  size;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        data_size_e  size;
    } stb_t;

    exp_t        exp_q[$];
    logic [31:0] exp_mem_q[$];
    stb_t        stb_q[$];
    logic [31:0] ld_q[$];
    int          ack_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int miss_left = 0;
    int mem_lat   = 1;
    int mem_cnt   = 0;
    int last_done_cyc = -1;
    int last_ack_cyc  = -1;
    bit ld_seen  = 0;
    bit st_seen  = 0;
    bit mem_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester models: loads held until done, store head held until ack.
    initial forever begin
        @(posedge clk);
        #1;
        if (ld_seen) begin
            ld_seen = 0;
            if (ld_q.size() != 0) void'(ld_q.pop_front());
        end
        if (st_seen) begin
            st_seen = 0;
            if (stb_q.size() != 0) void'(stb_q.pop_front());
        end
        ld_req_in    = (ld_q.size() != 0);
        ld_addr_in   = (ld_q.size() != 0) ? ld_q[0] : 32'h0;
        stb_flush_in = (stb_q.size() != 0);
        stb_addr_in  = (stb_q.size() != 0) ? stb_q[0].addr : 32'h0;
        stb_data_in  = (stb_q.size() != 0) ? stb_q[0].data : 32'h0;
        stb_size_in  = (stb_q.size() != 0) ? stb_q[0].size : SIZE_BYTE;
    end

    // Cache and memory responder.
    initial forever begin
        @(negedge clk);
        mem_ready_in = 1'b0;
        if (cache_req_out) begin
            cache_hit_in = (miss_left == 0);
            if (miss_left > 0) miss_left--;
        end else begin
            cache_hit_in = 1'b0;
        end
        if (mem_req_out) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ready_in = 1'b1;
                mem_cnt = 0;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on every done/ack and every new refill.
    initial forever begin
        @(negedge clk);
        #1;
        if (reset) begin
            mem_prev = 0;
            continue;
        end
        if (ld_done_out && stb_ack_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_ack_overlap: got both pulses, expected at most one");
        end
        if (ld_done_out || stb_ack_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b ack=%0b, expected none", ld_done_out, stb_ack_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("op_kind", 32'(stb_ack_out), 32'(e.is_store));
                check("cache_addr", cache_addr_out, e.addr);
                check("cache_we", 32'(cache_we_out), 32'(e.is_store));
                check("cache_req", 32'(cache_req_out), 32'd1);
                if (e.is_store) begin
                    check("cache_wdata", cache_wdata_out, e.data);
                    check("cache_size", 32'(cache_size_out), 32'(e.size));
                end else begin
                    check("stall_at_done", 32'(stall_out), 32'd0);
                end
            end
            if (ld_done_out) begin
                ld_seen = 1;
                last_done_cyc = cyc;
            end
            if (stb_ack_out) begin
                st_seen = 1;
                last_ack_cyc = cyc;
                ack_cyc.push_back(cyc);
                if (ld_req_in) check("drain_stalls_load", 32'(stall_out), 32'd1);
            end
        end
        if (mem_req_out && !mem_prev) begin
            if (exp_mem_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_refill: got addr 0x%0h, expected no refill", mem_addr_out);
            end else begin
                check("mem_addr", mem_addr_out, exp_mem_q.pop_front());
            end
        end
        mem_prev = mem_req_out;
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ld_q.size() == 0 && stb_q.size() == 0) break;
        end
        check(name, 32'(exp_q.size() + ld_q.size() + stb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        check(name, {23'd0, cache_req_out, cache_we_out, ld_done_out, stb_ack_out, mem_req_out,
                     stall_out, |cache_addr_out, |mem_addr_out, |cache_wdata_out}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int t0;
        bit found;
        reset = 1'b1;
        ld_req_in = 0; ld_addr_in = 0;
        stb_flush_in = 0; stb_addr_in = 0; stb_data_in = 0; stb_size_in = SIZE_BYTE;
        cache_hit_in = 0; mem_ready_in = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check_quiet("idle_outputs");
            check("idle_state", 32'(dut.state_q), 32'(IDLE));
        end

        // Load hit.
        @(negedge clk);
        exp_q.push_back('{1'b0, 32'h100, 32'h0, SIZE_BYTE});
        ld_q.push_back(32'h100);
        t0 = cyc;
        wait_drain("load_hit_drain");
        check("load_hit_latency", 32'(last_done_cyc), 32'(t0 + 2));

        // Store miss, memory ready on the 5th refill cycle.
        miss_left = 1;
        mem_lat   = 5;
        @(negedge clk);
        exp_q.push_back('{1'b1, 32'h204, 32'hDEADBEEF, SIZE_WORD});
        exp_mem_q.push_back(32'h200);
        stb_q.push_back('{32'h204, 32'hDEADBEEF, SIZE_WORD});
        ack_cyc.delete();
        t0 = cyc;
        wait_drain("store_miss_drain");
        check("store_miss_latency", 32'(last_ack_cyc), 32'(t0 + 8));
        check("store_miss_single_ack", 32'(ack_cyc.size()), 32'd1);

        // Simultaneous requests, counter at zero: load first.
        @(negedge clk);
        exp_q.push_back('{1'b0, 32'h140, 32'h0, SIZE_BYTE});
        exp_q.push_back('{1'b1, 32'h308, 32'h12345678, SIZE_HALF});
        ld_q.push_back(32'h140);
        stb_q.push_back('{32'h308, 32'h12345678, SIZE_HALF});
        wait_drain("simultaneous_drain");

        // Starvation: four loads win, then the drain is forced.
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'h400 + 32'(i * 16), 32'h0, SIZE_BYTE});
        exp_q.push_back('{1'b1, 32'h500, 32'hCAFEF00D, SIZE_BYTE});
        for (int i = 4; i < 6; i++) exp_q.push_back('{1'b0, 32'h400 + 32'(i * 16), 32'h0, SIZE_BYTE});
        for (int i = 0; i < 6; i++) ld_q.push_back(32'h400 + 32'(i * 16));
        stb_q.push_back('{32'h500, 32'hCAFEF00D, SIZE_BYTE});
        wait_drain("starvation_drain");
        check("starve_cleared", 32'(dut.starve_q), 32'd0);

        // Back-to-back drains, all hits.
        @(negedge clk);
        ack_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b1, 32'h600 + 32'(i * 4), 32'hA0 + 32'(i), SIZE_WORD});
            stb_q.push_back('{32'h600 + 32'(i * 4), 32'hA0 + 32'(i), SIZE_WORD});
        end
        wait_drain("b2b_drain");
        check("b2b_ack_count", 32'(ack_cyc.size()), 32'd3);
        if (ack_cyc.size() == 3) begin
            check("b2b_spacing_0", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
            check("b2b_spacing_1", 32'(ack_cyc[2] - ack_cyc[1]), 32'd2);
        end

        // Reset during a refill abandons the store with no ack.
        miss_left = 1;
        mem_lat   = 1000;
        @(negedge clk);
        exp_mem_q.push_back(32'h300);
        stb_q.push_back('{32'h30C, 32'h55AA55AA, SIZE_WORD});
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (mem_req_out) begin
                found = 1;
                break;
            end
        end
        check("refill_reached", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_mem_req", 32'(mem_req_out), 32'd0);
        stb_q.delete();
        ld_q.delete();
        ld_seen = 0;
        st_seen = 0;
        miss_left = 0;
        mem_lat = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check_quiet("post_reset_quiet");
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("refill_sb_empty", 32'(exp_mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
